pc_fetch: RTL

Program-counter register and instruction-fetch sequencer for the NPC core; sits directly downstream of the branch-condition unit and consumes its `pc_a_src`/`pc_b_src` selects. It holds the architectural PC and issues one fetch request per instruction over a valid/ready handshake to instruction memory. It presents the fetched instruction to decode and, on retire, computes the next PC as `(pc_b_src ? rs1 : pc) + (pc_a_src ? imm : 4)`. It traps to a sticky fault state on a misaligned target.

---
 rtl/npc_pkg.sv | 23 ++
 rtl/pc_fetch_if.sv | 40 ++++
 rtl/pc_next_adder.sv | 37 +++
 rtl/pc_fetch.sv | 86 ++++++++
 4 files changed

// File: rtl/npc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : npc_pkg
// Brief    : Shared types and constants for the NPC fetch path.
// Revision : 1.0
// ============================================================================
package npc_pkg;

    localparam int unsigned NPC_XLEN      = 32;
    localparam logic [31:0] NPC_RESET_VEC = 32'h8000_0000;
    localparam int unsigned PC_STEP       = 4;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_fetch_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch_if
// Brief    : Fetch-unit bundle: next-PC operands, imem handshake, decode side.
// Revision : 1.0
// ============================================================================
interface pc_fetch_if
    import npc_pkg::*;
#(
    parameter int XLEN = NPC_XLEN
);
    logic            pc_a_src;
    logic            pc_b_src;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            retire;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            fault;

    modport master (
        input  pc_a_src, pc_b_src, imm, rs1, retire,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output imem_req_valid, imem_addr, inst_valid, inst, pc, fault
    );

    modport slave (
        output pc_a_src, pc_b_src, imm, rs1, retire,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  imem_req_valid, imem_addr, inst_valid, inst, pc, fault
    );
endinterface
`default_nettype wire

// File: rtl/pc_next_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_next_adder
// Brief    : Next-PC operand muxes, modulo-2^XLEN add and misalign detect.
// Revision : 1.0
// ============================================================================
module pc_next_adder
    import npc_pkg::*;
#(
    parameter int XLEN = NPC_XLEN
) (
    input  wire             pc_a_src_i,
    input  wire             pc_b_src_i,
    input  wire [XLEN-1:0]  pc_i,
    input  wire [XLEN-1:0]  imm_i,
    input  wire [XLEN-1:0]  rs1_i,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_sum;

    always_comb begin
        w_op_a = pc_a_src_i ? imm_i : XLEN'(PC_STEP);
        w_op_b = pc_b_src_i ? rs1_i : pc_i;
        w_sum  = w_op_a + w_op_b;
        // jalr drops bit 0 before the alignment check, so only bit 1 can trap it
        if (pc_b_src_i) begin
            w_sum[0] = 1'b0;
        end
        target_o   = w_sum;
        misalign_o = |w_sum[1:0];
    end
endmodule
`default_nettype wire

// File: rtl/pc_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Brief    : Architectural PC register and one-request-per-instruction fetch FSM.
// Revision : 1.0
// ============================================================================
module pc_fetch
    import npc_pkg::*;
#(
    parameter int              XLEN      = NPC_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(NPC_RESET_VEC)
) (
    input  wire         clk,
    input  wire         rst_n,
    pc_fetch_if.master  fetch
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] w_target;
    logic            w_misalign;

    pc_next_adder #(.XLEN(XLEN)) u_adder (
        .pc_a_src_i (fetch.pc_a_src),
        .pc_b_src_i (fetch.pc_b_src),
        .pc_i       (pc_q),
        .imm_i      (fetch.imm),
        .rs1_i      (fetch.rs1),
        .target_o   (w_target),
        .misalign_o (w_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VEC;
            inst_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                if (fetch.imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fetch.imem_rsp_valid) begin
                    inst_d  = fetch.imem_rsp_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // a misaligned target leaves pc on the faulting instruction
                if (fetch.retire) begin
                    if (w_misalign) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = w_target;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_BOOT;
        endcase
    end

    assign fetch.imem_req_valid = (state_q == ST_REQ);
    assign fetch.imem_addr      = pc_q;
    assign fetch.inst_valid     = (state_q == ST_EXEC);
    assign fetch.inst           = inst_q;
    assign fetch.pc             = pc_q;
    assign fetch.fault          = (state_q == ST_FAULT);
endmodule
`default_nettype wire
